// File: rtl/anchor_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// anchor_pkg
//  Shared types and default parameter values for the anchor scan controller.
//  Contents:
//   state_t          controller FSM state encoding
//   DEF_*            default values for the anchor_scan_ctrl parameters
// ---------------------------------------------------------------------------
package anchor_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        PROCESSING = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam int unsigned DEF_COORD_W    = 16;
    localparam int unsigned DEF_NUM_STAGES = 5;
    localparam int unsigned DEF_BLOCK_W    = 10;
    localparam int unsigned DEF_X_FIRST    = 5;
    localparam int unsigned DEF_Y_OFFSET   = 5;

endpackage

// File: rtl/anchor_scan_ctrl_stride_counter.sv
// ---------------------------------------------------------------------------
// stride_counter
//  Register that steps by a fixed stride. Used for both anchor coordinates.
//  Priority: clear (back to START) > load (take load_val) > enable (+STRIDE).
//  Ports:
//   clk       in   1   clock
//   rst       in   1   synchronous active-high reset (to START)
//   clear     in   1   return to START
//   enable    in   1   advance by STRIDE
//   load      in   1   load load_val
//   load_val  in   W   value taken when load is high
//   count     out  W   current value
// ---------------------------------------------------------------------------
module stride_counter #(
    parameter int unsigned W      = 16,
    parameter int unsigned START  = 0,
    parameter int unsigned STRIDE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] START_V  = W'(START);
    localparam logic [W-1:0] STRIDE_V = W'(STRIDE);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = START_V;
        end else if (load) begin
            count_d = load_val;
        end else if (enable) begin
            count_d = count_q + STRIDE_V;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= START_V;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/anchor_scan_ctrl.sv
// ---------------------------------------------------------------------------
// anchor_scan_ctrl
//  Walks a processing anchor column-by-column over a width x height image in
//  BLOCK_W-wide vertical strips. Each strip scans y = 0 .. height+Y_OFFSET-1
//  (the extra rows drain the vertical pipeline), then the anchor steps right
//  by BLOCK_W. The anchor advances only when every stage reports final.
//  Ports:
//   clk            in   1           clock
//   rst            in   1           synchronous active-high reset
//   en_filter      in   1           start request (sampled in IDLE only)
//   abort          in   1           cancel run, back to IDLE, no done
//   hold           in   1           stall the anchor
//   stage_final    in   NUM_STAGES  per-stage "completes next cycle"
//   width, height  in   COORD_W     image geometry, latched in LOAD
//   anchor_moving  out  1           anchor advances on this edge (comb)
//   anchor_x/y     out  COORD_W     current anchor
//   col_start      out  1           first cycle at y=0 of a strip
//   busy           out  1           high in LOAD and PROCESSING
//   process_done   out  1           1-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module anchor_scan_ctrl
    import anchor_pkg::*;
#(
    parameter int unsigned COORD_W    = DEF_COORD_W,
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned BLOCK_W    = DEF_BLOCK_W,
    parameter int unsigned X_FIRST    = DEF_X_FIRST,
    parameter int unsigned Y_OFFSET   = DEF_Y_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_filter,
    input  logic                  abort,
    input  logic                  hold,
    input  logic [NUM_STAGES-1:0] stage_final,
    input  logic [COORD_W-1:0]    width,
    input  logic [COORD_W-1:0]    height,
    output logic                  anchor_moving,
    output logic [COORD_W-1:0]    anchor_x,
    output logic [COORD_W-1:0]    anchor_y,
    output logic                  col_start,
    output logic                  busy,
    output logic                  process_done
);

    localparam int unsigned CW1 = COORD_W + 1;
    localparam int unsigned CW2 = COORD_W + 2;

    state_t state_q, state_d;

    logic [COORD_W-1:0] width_q,  width_d;
    logic [COORD_W-1:0] height_q, height_d;
    logic [COORD_W:0]   col_base_q, col_base_d;
    logic               col_start_q, col_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               all_final;
    logic               abort_act;
    logic               clear_anchor;
    logic               wrap;
    logic [COORD_W:0]   y_end;
    logic [COORD_W+1:0] col_reach;
    logic               last_col;
    logic               at_y_end;
    logic               last_pos;

    // ---------------- compare logic ----------------
    assign all_final = &stage_final;
    assign abort_act = abort && (state_q != IDLE);

    // Extra bit keeps height + Y_OFFSET from wrapping for large images.
    assign y_end     = {1'b0, height_q} + CW1'(Y_OFFSET) - CW1'(1);

    // Last strip when this strip reaches or passes the right edge; this gives
    // ceil(width / BLOCK_W) strips without needing a divider.
    assign col_reach = {1'b0, col_base_q} + CW2'(BLOCK_W);
    assign last_col  = (col_reach >= {2'b00, width_q});
    assign at_y_end  = ({1'b0, anchor_y} == y_end);
    assign last_pos  = last_col && at_y_end;

    // Anchors go back to strip 0 / row 0 at the start of every run and on abort.
    assign clear_anchor = (state_q == LOAD) || abort_act;

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (en_filter) state_d = LOAD;
            LOAD:       state_d = ((width == '0) || (height == '0)) ? DONE : PROCESSING;
            PROCESSING: if (all_final && !hold && last_pos) state_d = DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        // abort beats both finishing and moving
        if (abort_act) begin
            state_d = IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        anchor_moving = (state_q == PROCESSING) && all_final && !hold && !abort && !last_pos;
        wrap          = anchor_moving && at_y_end;

        width_d  = (state_q == LOAD) ? width  : width_q;
        height_d = (state_q == LOAD) ? height : height_q;

        col_base_d = col_base_q;
        if (clear_anchor) begin
            col_base_d = '0;
        end else if (wrap) begin
            col_base_d = col_base_q + CW1'(BLOCK_W);
        end

        // Registered strobe: first cycle of strip 0 (after LOAD) or of a new strip.
        col_start_d = (state_d == PROCESSING) && ((state_q == LOAD) || wrap);
        busy_d      = (state_d == LOAD) || (state_d == PROCESSING);
        done_d      = (state_d == DONE);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_base_q  <= '0;
            col_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_base_q  <= col_base_d;
            col_start_q <= col_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ---------------- anchor coordinate counters ----------------
    stride_counter #(
        .W      (COORD_W),
        .START  (0),
        .STRIDE (1)
    ) u_y_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_anchor),
        .enable   (anchor_moving),
        .load     (wrap),          // back to row 0 when stepping to the next strip
        .load_val ('0),
        .count    (anchor_y)
    );

    stride_counter #(
        .W      (COORD_W),
        .START  (X_FIRST),
        .STRIDE (BLOCK_W)
    ) u_x_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_anchor),
        .enable   (wrap),
        .load     (1'b0),
        .load_val ('0),
        .count    (anchor_x)
    );

    assign col_start    = col_start_q;
    assign busy         = busy_q;
    assign process_done = done_q;

endmodule

// File: tb/tb_anchor_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_anchor_scan_ctrl
//  Directed bench for anchor_scan_ctrl: per-cycle vector tables for full runs
//  plus hand-written sequences for stall, abort and reset corners.
// ---------------------------------------------------------------------------
module tb_anchor_scan_ctrl;

    localparam int CW = 16;
    localparam int NS = 5;
    localparam logic [NS-1:0] ALL1 = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_filter;
    logic          abort;
    logic          hold;
    logic [NS-1:0] stage_final;
    logic [CW-1:0] width;
    logic [CW-1:0] height;
    logic          anchor_moving;
    logic [CW-1:0] anchor_x;
    logic [CW-1:0] anchor_y;
    logic          col_start;
    logic          busy;
    logic          process_done;

    always #5 clk = ~clk;

    anchor_scan_ctrl #(
        .COORD_W    (CW),
        .NUM_STAGES (NS),
        .BLOCK_W    (10),
        .X_FIRST    (5),
        .Y_OFFSET   (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_filter     (en_filter),
        .abort         (abort),
        .hold          (hold),
        .stage_final   (stage_final),
        .width         (width),
        .height        (height),
        .anchor_moving (anchor_moving),
        .anchor_x      (anchor_x),
        .anchor_y      (anchor_y),
        .col_start     (col_start),
        .busy          (busy),
        .process_done  (process_done)
    );

    typedef struct {
        logic          en;
        logic          ab;
        logic          hd;
        logic [NS-1:0] sf;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
        bit            chk_xy;
        int            ex;
        int            ey;
        logic          emv;
        logic          ecs;
        logic          ebusy;
        logic          edone;
    } vec_t;

    vec_t vec[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".x"},    32'(anchor_x), 5);
        chk({tag, ".y"},    32'(anchor_y), 0);
        chk({tag, ".mv"},   32'(anchor_moving), 0);
        chk({tag, ".cs"},   32'(col_start), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(process_done), 0);
    endtask

    // Expected cycle-by-cycle trace of a complete run with all stages final.
    task automatic build_run(input int w, input int h);
        vec_t v;
        int   strips;
        int   rows;
        strips = (w + 9) / 10;
        rows   = h + 5;
        v = '{en:1'b1, ab:1'b0, hd:1'b0, sf:ALL1, w:CW'(w), h:CW'(h), chk_xy:1'b0,
              ex:0, ey:0, emv:1'b0, ecs:1'b0, ebusy:1'b0, edone:1'b0};
        vec.push_back(v);                          // IDLE, request start
        v.en = 1'b0; v.ebusy = 1'b1;
        vec.push_back(v);                          // LOAD
        if (w == 0 || h == 0) begin
            v.chk_xy = 1'b1; v.ex = 5; v.ey = 0;
        end else begin
            v.chk_xy = 1'b1;
            for (int s = 0; s < strips; s++) begin
                for (int r = 0; r < rows; r++) begin
                    v.ex  = 5 + 10 * s;
                    v.ey  = r;
                    v.ecs = (r == 0);
                    v.emv = !((s == strips - 1) && (r == rows - 1));
                    vec.push_back(v);
                end
            end
        end
        v.emv = 1'b0; v.ecs = 1'b0; v.ebusy = 1'b0; v.edone = 1'b1;
        vec.push_back(v);                          // DONE
        v.edone = 1'b0;
        vec.push_back(v);                          // back in IDLE
    endtask

    task automatic apply_table(input string tag, output int moves);
        moves = 0;
        foreach (vec[i]) begin
            en_filter   = vec[i].en;
            abort       = vec[i].ab;
            hold        = vec[i].hd;
            stage_final = vec[i].sf;
            width       = vec[i].w;
            height      = vec[i].h;
            #1;
            $display("%s[%0d] x=%0d y=%0d mv=%0d cs=%0d busy=%0d done=%0d",
                     tag, i, anchor_x, anchor_y, anchor_moving, col_start, busy, process_done);
            if (vec[i].chk_xy) begin
                chk($sformatf("%s[%0d].x", tag, i), 32'(anchor_x), 32'(vec[i].ex));
                chk($sformatf("%s[%0d].y", tag, i), 32'(anchor_y), 32'(vec[i].ey));
            end
            chk($sformatf("%s[%0d].mv", tag, i),   32'(anchor_moving), 32'(vec[i].emv));
            chk($sformatf("%s[%0d].cs", tag, i),   32'(col_start),     32'(vec[i].ecs));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(busy),          32'(vec[i].ebusy));
            chk($sformatf("%s[%0d].done", tag, i), 32'(process_done),  32'(vec[i].edone));
            if (anchor_moving === 1'b1) moves++;
            tick();
        end
        vec.delete();
    endtask

    // Start a 20x3 run and stop on the first PROCESSING cycle at (5,0).
    task automatic start_run();
        en_filter = 1'b1; width = 16'd20; height = 16'd3; stage_final = ALL1;
        tick();
        en_filter = 1'b0;
        tick();
    endtask

    initial begin
        int moves;
        rst = 1'b1; en_filter = 1'b0; abort = 1'b0; hold = 1'b0;
        stage_final = ALL1; width = '0; height = '0;
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // 1) 20x3: two strips of 8 rows, 15 moves
        build_run(20, 3);
        apply_table("t1", moves);
        chk("t1.moves", 32'(moves), 15);

        // 2) 21x1: three strips of 6 rows, 17 moves
        build_run(21, 1);
        apply_table("t2", moves);
        chk("t2.moves", 32'(moves), 17);

        // 3) stalls at (5,3): missing stage_final, then hold
        start_run();
        tick(); tick(); tick();
        chk("t3.at_x", 32'(anchor_x), 5);
        chk("t3.at_y", 32'(anchor_y), 3);
        stage_final = 5'b11011;
        for (int k = 0; k < 4; k++) begin
            #1;
            $display("t3.sf[%0d] x=%0d y=%0d mv=%0d", k, anchor_x, anchor_y, anchor_moving);
            chk($sformatf("t3.sf%0d.y", k),  32'(anchor_y), 3);
            chk($sformatf("t3.sf%0d.mv", k), 32'(anchor_moving), 0);
            tick();
        end
        stage_final = ALL1;
        tick();
        chk("t3.sf_resume.y", 32'(anchor_y), 4);
        chk("t3.sf_resume.x", 32'(anchor_x), 5);
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            $display("t3.hold[%0d] x=%0d y=%0d mv=%0d", k, anchor_x, anchor_y, anchor_moving);
            chk($sformatf("t3.hd%0d.y", k),  32'(anchor_y), 4);
            chk($sformatf("t3.hd%0d.mv", k), 32'(anchor_moving), 0);
            tick();
        end
        hold = 1'b0;
        tick();
        chk("t3.hd_resume.y", 32'(anchor_y), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_reset_vals("t3.abort");

        // 4) abort at (15,2), then a fresh run completes
        start_run();
        for (int k = 0; k < 10; k++) tick();
        chk("t4.at_x", 32'(anchor_x), 15);
        chk("t4.at_y", 32'(anchor_y), 2);
        abort = 1'b1;
        #1;
        chk("t4.abort_mv", 32'(anchor_moving), 0);
        tick();
        abort = 1'b0;
        $display("t4.abort x=%0d y=%0d busy=%0d done=%0d", anchor_x, anchor_y, busy, process_done);
        chk_reset_vals("t4.idle");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t4.nodone%0d", k), 32'(process_done), 0);
        end
        build_run(20, 3);
        apply_table("t4r", moves);
        chk("t4r.moves", 32'(moves), 15);

        // hold at the last position blocks DONE; abort there gives no done
        start_run();
        for (int k = 0; k < 15; k++) tick();
        chk("t4h.last_x", 32'(anchor_x), 15);
        chk("t4h.last_y", 32'(anchor_y), 7);
        hold = 1'b1;
        tick(); tick();
        chk("t4h.busy", 32'(busy), 1);
        chk("t4h.done", 32'(process_done), 0);
        hold = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_reset_vals("t4h.abort");

        // 5) empty images: LOAD -> DONE, no moves
        build_run(0, 3);
        apply_table("t5w", moves);
        chk("t5w.moves", 32'(moves), 0);
        build_run(20, 0);
        apply_table("t5h", moves);
        chk("t5h.moves", 32'(moves), 0);

        // 6) reset mid-run, then geometry changes mid-run are ignored
        start_run();
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("t6.rst");
        tick();
        build_run(20, 3);
        for (int i = 2; i < vec.size(); i++) begin
            vec[i].w = 16'd40;
            vec[i].h = 16'd9;
        end
        apply_table("t6", moves);
        chk("t6.moves", 32'(moves), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
